// File: rtl/riptide_cfg_pkg.sv
// Shared types and defaults for the PE configuration chain loader.
package riptide_cfg_pkg;

  localparam int DEFAULT_CFG_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} cfg_ld_state_e;

endpackage

// File: rtl/cfg_rb_fifo.sv
// Two-entry readback FIFO holding words that fall out of the chain tail.
module cfg_rb_fifo
  import riptide_cfg_pkg::*;
#(
  parameter int CFG_WIDTH = DEFAULT_CFG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [CFG_WIDTH-1:0] wdata,
  output logic [1:0]           count,
  output logic [CFG_WIDTH-1:0] head
);

  logic [CFG_WIDTH-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Transmit end of the PE configuration daisy chain: shifts host words into the
// chain head and streams the displaced tail words back out.
module cfg_chain_loader
  import riptide_cfg_pkg::*;
#(
  parameter int CFG_WIDTH = DEFAULT_CFG_WIDTH,
  parameter int NUM_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [CFG_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 cfg_en,
  output logic [CFG_WIDTH-1:0] cfg_out,
  input  logic [CFG_WIDTH-1:0] cfg_tail,
  output logic                 rb_valid,
  output logic [CFG_WIDTH-1:0] rb_data,
  input  logic                 rb_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS);

  cfg_ld_state_e  state;
  cfg_ld_state_e  state_nxt;
  logic [CNT_W-1:0] issued;
  logic [1:0]     fifo_count;
  logic [1:0]     credit_used;
  logic           rb_pop;
  logic           xfer;

  assign rb_valid = (fifo_count != 2'd0);
  assign rb_pop   = rb_valid && rb_ready;
  assign xfer     = in_valid && in_ready;

  // Entries left after this cycle's pop plus the push already in flight on
  // cfg_en; a new word is accepted only if its tail push will find room.
  assign credit_used = fifo_count - {1'b0, rb_pop} + {1'b0, cfg_en};

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready = (issued < LAST) && (credit_used < 2'd2);
        if ((issued == LAST) && !cfg_en) state_nxt = DRAIN;
      end
      DRAIN: if (fifo_count == 2'd0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage boundary: accepted host word -> chain head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued  <= '0;
      cfg_en  <= 1'b0;
      cfg_out <= '0;
    end else begin
      cfg_en <= xfer && !clear;
      if (xfer && !clear) cfg_out <= in_data;
      if (clear || ((state == IDLE) && start)) issued <= '0;
      else if (xfer && (issued != LAST))      issued <= issued + 1'b1;
    end
  end

  cfg_rb_fifo #(
    .CFG_WIDTH (CFG_WIDTH)
  ) u_rb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cfg_en),
    .pop   (rb_pop),
    .flush (clear),
    .wdata (cfg_tail),
    .count (fifo_count),
    .head  (rb_data)
  );

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: a behavioural PE chain feeds cfg_tail, directed
// vectors and load sequences check shifting, readback order and control.
module tb_cfg_chain_loader;

  localparam int W  = 32;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, clear, in_valid, in_ready, cfg_en, rb_valid, rb_ready, busy, done;
  logic [W-1:0] in_data, cfg_out, cfg_tail, rb_data;
  logic [W-1:0] chain [NW];

  logic         rst1, start1, clear1, in_valid1, in_ready1, cfg_en1, rb_valid1, rb_ready1, busy1, done1;
  logic [W-1:0] in_data1, cfg_out1, cfg_tail1, rb_data1;
  logic [W-1:0] chain1;

  assign cfg_tail  = chain[NW-1];
  assign cfg_tail1 = chain1;

  cfg_chain_loader #(.CFG_WIDTH(W), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .cfg_en(cfg_en), .cfg_out(cfg_out),
    .cfg_tail(cfg_tail), .rb_valid(rb_valid), .rb_data(rb_data), .rb_ready(rb_ready),
    .busy(busy), .done(done)
  );

  cfg_chain_loader #(.CFG_WIDTH(W), .NUM_WORDS(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .clear(clear1), .in_valid(in_valid1),
    .in_data(in_data1), .in_ready(in_ready1), .cfg_en(cfg_en1), .cfg_out(cfg_out1),
    .cfg_tail(cfg_tail1), .rb_valid(rb_valid1), .rb_data(rb_data1), .rb_ready(rb_ready1),
    .busy(busy1), .done(done1)
  );

  // PE chain models: preloaded on reset, shift on cfg_en
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) chain[i] <= 32'h10 + i;
    end else if (cfg_en) begin
      chain[0] <= cfg_out;
      for (int i = 1; i < NW; i++) chain[i] <= chain[i-1];
    end
    if (rst1)         chain1 <= 32'h55;
    else if (cfg_en1) chain1 <= cfg_out1;
  end

  int           shift_cnt = 0;
  int           done_cnt  = 0;
  int           hold_bad  = 0;
  logic [W-1:0] prev_out  = '0;
  logic [W-1:0] rb_q[$];
  logic [W-1:0] sh_q[$];

  always @(posedge clk) begin
    if (cfg_en) begin
      shift_cnt <= shift_cnt + 1;
      sh_q.push_back(cfg_out);
    end
    if (rb_valid && rb_ready) rb_q.push_back(rb_data);
    if (done) done_cnt <= done_cnt + 1;
    if (!rst && !cfg_en && (cfg_out !== prev_out)) hold_bad <= hold_bad + 1;
    prev_out <= cfg_out;
  end

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic         start;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         e_in_ready;
    logic         e_cfg_en;
    logic [W-1:0] e_cfg_out;
    logic         e_rb_valid;
    logic [W-1:0] e_rb_data;
    logic         e_busy;
    logic         e_done;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic iv, input logic [W-1:0] d,
                              input logic ir, input logic en, input logic [W-1:0] co,
                              input logic rv, input logic [W-1:0] rd, input logic bz,
                              input logic dn);
    vec_t v;
    v.start = s; v.in_valid = iv; v.in_data = d;
    v.e_in_ready = ir; v.e_cfg_en = en; v.e_cfg_out = co;
    v.e_rb_valid = rv; v.e_rb_data = rd; v.e_busy = bz; v.e_done = dn;
    return v;
  endfunction

  task automatic load_seq(input logic [W-1:0] base, input int pvalid, input int hold_rb,
                          input bit start_mid, input string tag);
    logic [W-1:0] exp [NW];
    int sent, cyc, sh0, d0, rb0, hb0;
    bit xfer;
    for (int k = 0; k < NW; k++) exp[k] = chain[NW-1-k];
    sent = 0; cyc = 0;
    sh0 = shift_cnt; d0 = done_cnt; rb0 = rb_q.size(); hb0 = hold_bad;
    @(negedge clk); start = 1'b1; rb_ready = (hold_rb == 0);
    @(negedge clk); start = 1'b0;
    while (done_cnt == d0 && cyc < 100) begin
      rb_ready = (cyc >= hold_rb);
      start    = start_mid && (cyc == 2);
      in_valid = (sent < NW) && ($urandom_range(0, 99) < pvalid);
      in_data  = base + sent;
      #1;
      xfer = in_valid && in_ready;
      if (hold_rb > 0 && cyc == hold_rb - 1) begin
        chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
        chk({tag, "_hold_shifts_le2"}, (shift_cnt - sh0) <= 2, 1'b1);
        chk({tag, "_hold_no_rb"}, rb_q.size() - rb0, 0);
      end
      if (start_mid && cyc == 3) chk({tag, "_busy_after_start"}, busy, 1'b1);
      @(posedge clk);
      if (xfer) sent++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; rb_ready = 1'b1;
    #1;
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_busy_after_done"}, busy, 1'b0);
    chk({tag, "_shift_count"}, shift_cnt - sh0, NW);
    chk({tag, "_rb_count"}, rb_q.size() - rb0, NW);
    chk({tag, "_hold_violations"}, hold_bad - hb0, 0);
    for (int k = 0; k < NW && (rb0 + k) < rb_q.size(); k++)
      chk({tag, "_rb_word"}, rb_q[rb0 + k], exp[k]);
    for (int k = 0; k < NW && (sh0 + k) < sh_q.size(); k++)
      chk({tag, "_shift_word"}, sh_q[sh0 + k], base + k);
  endtask

  vec_t tv [10];

  initial begin
    int sh0, d0, cyc;
    rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; rb_ready = 1'b1;
    rst1 = 1'b1; start1 = 1'b0; clear1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; rb_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_cfg_en", cfg_en, 1'b0);
    chk("rst_cfg_out", cfg_out, 32'h0);
    chk("rst_rb_valid", rb_valid, 1'b0);
    chk("rst_rb_data", rb_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0; rst1 = 1'b0;

    // Full load, back-to-back words, chain preloaded 0x10..0x13 (tail 0x13)
    tv[0] = mk(1, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 0, 0);
    tv[1] = mk(0, 1, 32'hA0, 1, 0, 32'h00, 0, 32'h00, 1, 0);
    tv[2] = mk(0, 1, 32'hA1, 1, 1, 32'hA0, 0, 32'h00, 1, 0);
    tv[3] = mk(0, 1, 32'hA2, 1, 1, 32'hA1, 1, 32'h13, 1, 0);
    tv[4] = mk(0, 1, 32'hA3, 1, 1, 32'hA2, 1, 32'h12, 1, 0);
    tv[5] = mk(0, 0, 32'h00, 0, 1, 32'hA3, 1, 32'h11, 1, 0);
    tv[6] = mk(0, 0, 32'h00, 0, 0, 32'hA3, 1, 32'h10, 1, 0);
    tv[7] = mk(0, 0, 32'h00, 0, 0, 32'hA3, 0, 32'h00, 1, 0);
    tv[8] = mk(0, 0, 32'h00, 0, 0, 32'hA3, 0, 32'h00, 1, 1);
    tv[9] = mk(0, 0, 32'h00, 0, 0, 32'hA3, 0, 32'h00, 0, 0);
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      start = tv[r].start; in_valid = tv[r].in_valid; in_data = tv[r].in_data;
      #1;
      chk($sformatf("t1_r%0d_in_ready", r), in_ready, tv[r].e_in_ready);
      chk($sformatf("t1_r%0d_cfg_en", r), cfg_en, tv[r].e_cfg_en);
      chk($sformatf("t1_r%0d_cfg_out", r), cfg_out, tv[r].e_cfg_out);
      chk($sformatf("t1_r%0d_rb_valid", r), rb_valid, tv[r].e_rb_valid);
      if (tv[r].e_rb_valid) chk($sformatf("t1_r%0d_rb_data", r), rb_data, tv[r].e_rb_data);
      chk($sformatf("t1_r%0d_busy", r), busy, tv[r].e_busy);
      chk($sformatf("t1_r%0d_done", r), done, tv[r].e_done);
    end
    start = 1'b0; in_valid = 1'b0;

    // Readback back-pressure, random in_valid gaps, start during LOAD
    load_seq(32'hB0, 100, 10, 1'b0, "t2");
    load_seq(32'hC0, 50, 0, 1'b0, "t3");
    load_seq(32'hD0, 100, 0, 1'b1, "t5");

    // clear after the second shift
    sh0 = shift_cnt; d0 = done_cnt; cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while ((shift_cnt - sh0) < 2 && cyc < 20) begin
      in_valid = 1'b1; in_data = 32'hE0 + cyc;
      @(negedge clk);
      cyc++;
    end
    chk("t4_reached_2_shifts", (shift_cnt - sh0) >= 2, 1'b1);
    clear = 1'b1; in_valid = 1'b0;
    @(negedge clk); clear = 1'b0;
    #1;
    chk("t4_busy", busy, 1'b0);
    chk("t4_cfg_en", cfg_en, 1'b0);
    chk("t4_rb_valid", rb_valid, 1'b0);
    chk("t4_in_ready", in_ready, 1'b0);
    repeat (5) @(negedge clk);
    chk("t4_no_done", done_cnt - d0, 0);
    load_seq(32'hF0, 100, 0, 1'b0, "t4_reload");

    // start together with clear in IDLE
    @(negedge clk); start = 1'b1; clear = 1'b1;
    @(negedge clk); start = 1'b0; clear = 1'b0;
    #1;
    chk("t5_startclear_busy", busy, 1'b0);
    chk("t5_startclear_cfg_en", cfg_en, 1'b0);

    // NUM_WORDS=1: single transfer load, then reset mid-LOAD
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; in_valid1 = 1'b1; in_data1 = 32'h77;
    #1; chk("t6_in_ready", in_ready1, 1'b1);
    @(negedge clk); in_valid1 = 1'b0;
    #1;
    chk("t6_cfg_en", cfg_en1, 1'b1);
    chk("t6_cfg_out", cfg_out1, 32'h77);
    chk("t6_in_ready_sat", in_ready1, 1'b0);
    @(negedge clk); #1;
    chk("t6_rb_valid", rb_valid1, 1'b1);
    chk("t6_rb_data", rb_data1, 32'h55);
    @(negedge clk); #1;
    chk("t6_drain_busy", busy1, 1'b1);
    chk("t6_drain_done", done1, 1'b0);
    @(negedge clk); #1;
    chk("t6_done", done1, 1'b1);
    @(negedge clk); #1;
    chk("t6_idle_busy", busy1, 1'b0);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; in_valid1 = 1'b1; in_data1 = 32'h99;
    @(negedge clk); in_valid1 = 1'b0; rst1 = 1'b1;
    #1; chk("t6_pre_rst_cfg_en", cfg_en1, 1'b1);
    @(negedge clk); #1;
    chk("t6_rst_in_ready", in_ready1, 1'b0);
    chk("t6_rst_cfg_en", cfg_en1, 1'b0);
    chk("t6_rst_cfg_out", cfg_out1, 32'h0);
    chk("t6_rst_rb_valid", rb_valid1, 1'b0);
    chk("t6_rst_rb_data", rb_data1, 32'h0);
    chk("t6_rst_busy", busy1, 1'b0);
    chk("t6_rst_done", done1, 1'b0);
    rst1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
